// File: rtl/keypad_hex_entry.sv
// keypad_hex_entry: 4x4 matrix keypad scanner with debounce, shifting accepted hex digits into a 16-bit entry register
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   col[3:0]      keypad columns, active-low, asynchronous to clk
//   clr           synchronous clear of value/ndigits
//   row[3:0]      keypad row drive, active-low, one-hot-zero
//   key_code[3:0] code {row, column} of the last accepted key
//   key_valid     one-cycle pulse per accepted key
//   key_held      high from acceptance until the release is accepted
//   value[15:0]   entry register, newest digit in [3:0]
//   ndigits[2:0]  digits entered since clear, saturating at 4
module keypad_hex_entry #(
    parameter int SCAN_DIV = 25000,
    parameter int DEBOUNCE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    input  logic        clr,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] value,
    output logic [2:0]  ndigits
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [1:0] S_SCAN = 2'd0;
    localparam logic [1:0] S_DEB  = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic [3:0]    s1, scol, low, code;
    logic [DW-1:0] div_cnt;
    logic [1:0]    state, r, c, cidx;
    logic [CW-1:0] mcnt, rcnt;
    logic          tick, single, accept, release_ok;

    assign low = ~scol;
    // exactly one column low; none or several (ghosting) is never a key
    assign single = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    assign cidx = low[1] ? 2'd1 : low[2] ? 2'd2 : low[3] ? 2'd3 : 2'd0;
    assign tick = div_cnt == DW'(SCAN_DIV - 1);
    assign code = {r, cidx};
    // with DEBOUNCE==1 the detect tick is itself the accepting tick
    assign accept = tick && single &&
                    ((state == S_SCAN && DEBOUNCE == 1) ||
                     (state == S_DEB && cidx == c && mcnt == LAST));
    assign release_ok = tick && state == S_HELD && scol == 4'hF && rcnt == LAST;
    assign row = ~(4'b0001 << r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 4'hF;
            scol <= 4'hF;
        end else begin
            s1   <= col;
            scol <= s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + DW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_SCAN;
            r     <= 2'd0;
            c     <= 2'd0;
            mcnt  <= '0;
            rcnt  <= '0;
        end else if (tick) begin
            case (state)
                S_SCAN: begin
                    if (single) begin
                        c     <= cidx;
                        mcnt  <= CW'(1);
                        rcnt  <= '0;
                        state <= accept ? S_HELD : S_DEB;
                    end else begin
                        r <= r + 2'd1;
                    end
                end
                S_DEB: begin
                    if (accept) begin
                        state <= S_HELD;
                        rcnt  <= '0;
                    end else if (single && cidx == c) begin
                        mcnt <= mcnt + CW'(1);
                    end else begin
                        state <= S_SCAN;
                        r     <= r + 2'd1;
                        mcnt  <= '0;
                    end
                end
                S_HELD: begin
                    // row stays frozen, so other keys cannot be seen until release
                    if (release_ok) begin
                        state <= S_SCAN;
                        r     <= r + 2'd1;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= (scol == 4'hF) ? rcnt + CW'(1) : '0;
                    end
                end
                default: state <= S_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            value     <= 16'h0000;
            ndigits   <= 3'd0;
        end else begin
            key_valid <= accept;
            key_code  <= accept ? code : key_code;
            key_held  <= accept | (key_held & ~release_ok);
            // a digit accepted alongside clr becomes the first digit
            value     <= clr ? (accept ? {12'h000, code} : 16'h0000)
                             : (accept ? {value[11:0], code} : value);
            ndigits   <= clr ? {2'b00, accept}
                             : (accept && ndigits != 3'd4) ? ndigits + 3'd1 : ndigits;
        end
    end
endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb_keypad_hex_entry: directed bench for keypad_hex_entry with a row-dependent keypad model
module tb_keypad_hex_entry;
    typedef struct {
        logic [3:0]  key;
        logic [15:0] v;
        logic [2:0]  nd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  col, row, key_code;
    logic        key_valid, key_held;
    logic [15:0] value;
    logic [2:0]  ndigits;
    logic [15:0] pressed = 16'h0000;
    int          checks = 0;
    int          errors = 0;
    int          nvalid = 0;
    int          ph = 0;

    always #5 clk = ~clk;

    keypad_hex_entry #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst(rst), .col(col), .clr(clr), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .value(value), .ndigits(ndigits)
    );

    // keypad: a pressed key shorts its column low while its row is driven
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
    end

    // bench timebase: ph==3 marks the sample-tick cycle of a 4-cycle dwell
    always @(posedge clk or posedge rst) begin
        if (rst) ph <= 0;
        else     ph <= (ph == 3) ? 0 : ph + 1;
    end

    always @(negedge clk) if (key_valid) nvalid <= nvalid + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic to_tick();
        do @(negedge clk); while (ph != 3);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin @(negedge clk); n++; end while (!key_valid && n < 200);
        chk("key_valid_seen", 32'(key_valid), 1);
    endtask

    task automatic wait_release();
        int n = 0;
        pressed = 16'h0000;
        do begin @(negedge clk); n++; end while (key_held && n < 200);
        chk("held_fall", 32'(key_held), 0);
    endtask

    task automatic row_steps();
        logic [3:0] e;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            e = ~(4'b0001 << ((i / 4) % 4));
            chk("row_step", 32'(row), 32'(e));
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_row", 32'(row), 32'hE);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_held", 32'(key_held), 0);
        chk("rst_value", 32'(value), 0);
        chk("rst_ndigits", 32'(ndigits), 0);
        chk("rst_code", 32'(key_code), 0);
    endtask

    initial begin
        vec_t       tbl[5];
        int         nv0;
        logic [3:0] seen;
        tbl[0] = '{4'h1, 16'h0001, 3'd1};
        tbl[1] = '{4'h2, 16'h0012, 3'd2};
        tbl[2] = '{4'h3, 16'h0123, 3'd3};
        tbl[3] = '{4'h4, 16'h1234, 3'd4};
        tbl[4] = '{4'h5, 16'h2345, 3'd4};

        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        row_steps();

        // rst during DEBOUNCE aborts; the still-pressed key is re-detected from scratch
        pressed = 16'h0002;
        to_tick(); to_tick(); to_tick();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_deb_nvalid", 32'(nvalid), 0);
        chk("rst_deb_held", 32'(key_held), 0);
        rst = 1'b0;
        repeat (3) begin
            to_tick();
            chk("redetect_early", 32'(key_valid), 0);
        end
        @(negedge clk);
        chk("redetect_valid", 32'(key_valid), 1);
        chk("redetect_code", 32'(key_code), 1);
        chk("redetect_value", 32'(value), 16'h0001);
        chk("redetect_nd", 32'(ndigits), 1);
        chk("redetect_held", 32'(key_held), 1);
        wait_release();

        // clr coincident with acceptance of key 7 (row 1 is now driven)
        pressed = 16'h0080;
        to_tick(); to_tick(); to_tick();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clracc_valid", 32'(key_valid), 1);
        chk("clracc_value", 32'(value), 16'h0007);
        chk("clracc_nd", 32'(ndigits), 1);
        wait_release();

        // clr alone
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_value", 32'(value), 0);
        chk("clr_nd", 32'(ndigits), 0);
        chk("clr_code_kept", 32'(key_code), 7);

        // long single press of key (2,1)
        nv0 = nvalid;
        pressed = 16'h0200;
        repeat (200) @(negedge clk);
        chk("single_count", 32'(nvalid - nv0), 1);
        chk("single_code", 32'(key_code), 9);
        chk("single_value", 32'(value), 16'h0009);
        chk("single_nd", 32'(ndigits), 1);
        chk("single_held", 32'(key_held), 1);
        to_tick();
        pressed = 16'h0000;
        repeat (3) begin
            to_tick();
            chk("held_before_fall", 32'(key_held), 1);
        end
        @(negedge clk);
        chk("held_after_fall", 32'(key_held), 0);

        // digit entry table
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pressed = 16'h0001 << tbl[i].key;
            wait_valid();
            chk("entry_code", 32'(key_code), 32'(tbl[i].key));
            chk("entry_value", 32'(value), 32'(tbl[i].v));
            chk("entry_nd", 32'(ndigits), 32'(tbl[i].nd));
            wait_release();
        end

        // mid-run reset
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        row_steps();

        // bounce on key (0,3): low 2 ticks, high 1 tick, low 2 ticks
        nv0 = nvalid;
        pressed = 16'h0008;
        to_tick(); to_tick();
        pressed = 16'h0000;
        to_tick();
        pressed = 16'h0008;
        to_tick(); to_tick();
        pressed = 16'h0000;
        seen = 4'h0;
        repeat (40) begin
            @(negedge clk);
            seen |= ~row;
        end
        chk("bounce_rows_scanned", 32'(seen), 32'hF);
        chk("bounce_nvalid", 32'(nvalid - nv0), 0);
        chk("bounce_value", 32'(value), 0);
        chk("bounce_nd", 32'(ndigits), 0);

        // ghosting: two columns low on row 1
        nv0 = nvalid;
        pressed = 16'h0050;
        repeat (100) @(negedge clk);
        chk("ghost_nvalid", 32'(nvalid - nv0), 0);
        pressed = 16'h0000;
        @(negedge clk);

        // key A pressed while key 5 is held
        pressed = 16'h0020;
        wait_valid();
        chk("hold5_code", 32'(key_code), 5);
        chk("hold5_value", 32'(value), 16'h0005);
        @(negedge clk);
        nv0 = nvalid;
        pressed = 16'h0420;
        repeat (100) @(negedge clk);
        chk("holdA_nvalid", 32'(nvalid - nv0), 0);
        chk("holdA_code", 32'(key_code), 5);
        chk("holdA_held", 32'(key_held), 1);
        chk("holdA_value", 32'(value), 16'h0005);
        wait_release();
        chk("holdA_after_release", 32'(nvalid - nv0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
